delay_mod_ctrl: RTL and testbench

Parametrised, sequential successor to the per-effect delay-setting decoder. It converts per-channel 4-bit settings into delay values in 1 ms units for the effect chain: echo, chorus, phaser and reverb. Each channel gets a base delay plus optional LFO modulation, and the value is slew-limited toward its target. Channels are updated serially, one per clock, on each `tick` strobe from the sample-rate timebase. The delay lines read `del` and may latch it on `del_valid`.

---
 rtl/delay_pkg.sv | 51 +++++
 rtl/delay_mod_ctrl_if.sv | 44 ++++
 rtl/delay_chan_calc.sv | 93 +++++++++
 rtl/delay_mod_ctrl.sv | 116 +++++++++++
 tb/tb_delay_mod_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/delay_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : delay_pkg
//  Description : Shared types and constants for the delay modulation
//                controller: base-delay table, modulation mode and FSM state
//                encodings, phase accumulator width, and small helpers that
//                decode a channel's settings nibble.
//  Config      : DELAY_SLEW_EN (used by delay_chan_calc, not by this package)
//  Revision    : 1.0 - initial release
// ============================================================================
package delay_pkg;

    // Phase accumulator width; wraps modulo 2**c_phase_w.
    localparam int c_phase_w = 10;

    // Base delay in ms, indexed by settings[1:0]. Entry [0] is the rightmost.
    localparam logic [3:0][10:0] c_base_delay = {11'd0, 11'd1500, 11'd1000, 11'd500};

    // Modulation mode, settings[3:2].
    typedef enum logic [1:0] {
        MODE_FIXED    = 2'b00,
        MODE_TRI_SLOW = 2'b01,
        MODE_TRI_FAST = 2'b10,
        MODE_SAW      = 2'b11
    } mode_e;

    // Sequencer state.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        UPDATE = 2'b01,
        DONE   = 2'b10
    } state_e;

    function automatic logic [10:0] base_delay(input logic [1:0] sel);
        return c_base_delay[sel];
    endfunction

    // Phase increment per update for each mode.
    function automatic logic [c_phase_w-1:0] phase_step(input mode_e mode);
        logic [c_phase_w-1:0] step;
        case (mode)
            MODE_TRI_SLOW: step = c_phase_w'(1);
            MODE_TRI_FAST: step = c_phase_w'(4);
            MODE_SAW:      step = c_phase_w'(1);
            default:       step = '0;
        endcase
        return step;
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_mod_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : delay_mod_ctrl_if
//  Description : Bus between the effect-chain host and the delay modulation
//                controller.
//                  tick      - single-cycle update strobe       (host -> ctrl)
//                  settings  - 4 bits per channel              (host -> ctrl)
//                  del       - DW bits per channel, registered  (ctrl -> host)
//                  del_valid - all channels updated this tick   (ctrl -> host)
//                  busy      - update sequence in progress      (ctrl -> host)
//                  overrun   - a tick was dropped while busy    (ctrl -> host)
//  Config      : DELAY_SLEW_EN (not used by this file)
//  Revision    : 1.0 - initial release
// ============================================================================
interface delay_mod_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int DW     = 12
);
    logic                   tick;
    logic [4*NUM_CH-1:0]    settings;
    logic [DW*NUM_CH-1:0]   del;
    logic                   del_valid;
    logic                   busy;
    logic                   overrun;

    modport master (
        output tick,
        output settings,
        input  del,
        input  del_valid,
        input  busy,
        input  overrun
    );

    modport slave (
        input  tick,
        input  settings,
        output del,
        output del_valid,
        output busy,
        output overrun
    );
endinterface
`default_nettype wire

// File: rtl/delay_chan_calc.sv
`default_nettype none
// ============================================================================
//  Module      : delay_chan_calc
//  Description : Combinational next-state calculation for one delay channel.
//                Advances the phase accumulator, derives the LFO modulation,
//                forms the saturated target and (optionally) slew-limits the
//                delay toward it. Shared by all channels through a mux.
//  Ports       : setting    - channel settings nibble (sel [1:0], mode [3:2])
//                phase      - current phase accumulator
//                cur_del    - current delay value
//                next_phase - updated phase accumulator
//                next_del   - updated delay value
//  Config      : DELAY_SLEW_EN - when defined, next_del moves at most SLEW
//                per update; otherwise next_del is the target directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_chan_calc
    import delay_pkg::*;
#(
    parameter int DW        = 12,
    parameter int MOD_SHIFT = 3,
    parameter int SLEW      = 16
) (
    input  logic [3:0]           setting,
    input  logic [c_phase_w-1:0] phase,
    input  logic [DW-1:0]        cur_del,
    output logic [c_phase_w-1:0] next_phase,
    output logic [DW-1:0]        next_del
);

    localparam int c_sum_w = DW + 1;

    mode_e                  w_mode;
    logic [c_phase_w-2:0]   w_tri;
    logic [c_phase_w-1:0]   w_mod;
    logic [c_sum_w-1:0]     w_sum;
    logic [DW-1:0]          w_target;

    always_comb begin
        w_mode = mode_e'(setting[3:2]);

        // Fixed mode pins the phase at 0 so a later switch to a modulated
        // mode starts from the bottom of the waveform.
        if (w_mode == MODE_FIXED) begin
            next_phase = '0;
        end else begin
            next_phase = phase + phase_step(w_mode);
        end

        // Fold the upper half of the phase to produce a 0..511 triangle.
        w_tri = next_phase[c_phase_w-1] ? ~next_phase[c_phase_w-2:0]
                                        :  next_phase[c_phase_w-2:0];

        case (w_mode)
            MODE_TRI_SLOW,
            MODE_TRI_FAST: w_mod = {1'b0, w_tri >> MOD_SHIFT};
            MODE_SAW:      w_mod = next_phase >> (MOD_SHIFT + 1);
            default:       w_mod = '0;
        endcase

        // One extra bit of headroom; any carry into it means saturate.
        w_sum    = c_sum_w'(base_delay(setting[1:0])) + c_sum_w'(w_mod);
        w_target = w_sum[DW] ? '1 : w_sum[DW-1:0];
    end

`ifdef DELAY_SLEW_EN
    localparam logic [DW-1:0] c_slew = DW'(SLEW);

    logic [DW-1:0] w_up;
    logic [DW-1:0] w_down;

    always_comb begin
        w_up   = w_target - cur_del;
        w_down = cur_del - w_target;
        if (w_target >= cur_del) begin
            next_del = (w_up <= c_slew) ? w_target : cur_del + c_slew;
        end else begin
            next_del = (w_down <= c_slew) ? w_target : cur_del - c_slew;
        end
    end
`else
    // The current delay only matters when slewing.
    logic w_unused_del;
    assign w_unused_del = ^cur_del;
    assign next_del     = w_target;

    // SLEW has no effect in this build.
    if (SLEW < 0) begin : g_slew_unused
    end
`endif

endmodule
`default_nettype wire

// File: rtl/delay_mod_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : delay_mod_ctrl
//  Description : Sequential delay-setting controller for the effect chain.
//                On each tick the channels are updated one per clock through
//                a single shared delay_chan_calc, then del_valid is pulsed.
//  Ports       : clk - system clock
//                rst - synchronous active-high reset
//                bus - delay_mod_ctrl_if slave (tick, settings, del,
//                      del_valid, busy, overrun)
//  Config      : DELAY_SLEW_EN - enables slew limiting in delay_chan_calc.
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_mod_ctrl
    import delay_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DW        = 12,
    parameter int MOD_SHIFT = 3,
    parameter int SLEW      = 16
) (
    input  logic            clk,
    input  logic            rst,
    delay_mod_ctrl_if.slave bus
);

    localparam int                c_ch_w    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [c_ch_w-1:0] c_last_ch = c_ch_w'(NUM_CH - 1);

    state_e                 r_state;
    logic [c_ch_w-1:0]      r_ch;
    logic [c_phase_w-1:0]   r_phase [NUM_CH];
    logic [DW-1:0]          r_del   [NUM_CH];
    logic                   r_del_valid;
    logic                   r_busy;
    logic                   r_overrun;

    logic [3:0]             w_setting;
    logic [c_phase_w-1:0]   w_next_phase;
    logic [DW-1:0]          w_next_del;

    // Only the channel being updated is presented to the calculator, so its
    // settings are sampled in exactly that channel's update cycle.
    assign w_setting = bus.settings[4*r_ch +: 4];

    delay_chan_calc #(
        .DW        (DW),
        .MOD_SHIFT (MOD_SHIFT),
        .SLEW      (SLEW)
    ) u_calc (
        .setting    (w_setting),
        .phase      (r_phase[r_ch]),
        .cur_del    (r_del[r_ch]),
        .next_phase (w_next_phase),
        .next_del   (w_next_del)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ch        <= '0;
            r_del_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_phase[i] <= '0;
                r_del[i]   <= '0;
            end
        end else begin
            r_del_valid <= 1'b0;
            r_overrun   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.tick) begin
                        r_state <= UPDATE;
                        r_ch    <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                UPDATE: begin
                    r_phase[r_ch] <= w_next_phase;
                    r_del[r_ch]   <= w_next_del;
                    // Ticks while sequencing are dropped, not queued.
                    r_overrun     <= bus.tick;
                    if (r_ch == c_last_ch) begin
                        r_state     <= DONE;
                        r_del_valid <= 1'b1;
                    end else begin
                        r_ch <= r_ch + 1'b1;
                    end
                end
                DONE: begin
                    r_overrun <= bus.tick;
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_ch      <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ch    <= '0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_del_out
        assign bus.del[DW*gi +: DW] = r_del[gi];
    end

    assign bus.del_valid = r_del_valid;
    assign bus.busy      = r_busy;
    assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_delay_mod_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_delay_mod_ctrl
//  Description : Self-checking bench for delay_mod_ctrl. Randomised settings
//                are applied per tick; a behavioural model predicts every
//                channel's delay, expectations are queued and popped by a
//                monitor on each del_valid. Directed sequences cover reset,
//                per-channel update timing, overrun and reset mid-update.
//  Config      : DELAY_SLEW_EN - the model and spot values follow the build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_mod_ctrl;

    localparam int c_num_ch    = 4;
    localparam int c_dw        = 12;
    localparam int c_mod_shift = 3;
    localparam int c_slew      = 16;
    localparam int c_max_del   = (1 << c_dw) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    delay_mod_ctrl_if #(.NUM_CH(c_num_ch), .DW(c_dw)) bus ();

    delay_mod_ctrl #(
        .NUM_CH    (c_num_ch),
        .DW        (c_dw),
        .MOD_SHIFT (c_mod_shift),
        .SLEW      (c_slew)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int m_ph  [c_num_ch];
    int m_del [c_num_ch];
    logic [c_num_ch*c_dw-1:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [c_dw-1:0] dut_del(input int c);
        return bus.del[c_dw*c +: c_dw];
    endfunction

    // Reference: phase walks a 0..1023 circle; triangle rises 0..511 then
    // falls back; delay chases base+modulation, capped at the DW maximum.
    function automatic void model_reset();
        for (int c = 0; c < c_num_ch; c++) begin
            m_ph[c]  = 0;
            m_del[c] = 0;
        end
    endfunction

    function automatic void model_tick(input logic [4*c_num_ch-1:0] s);
        int sel, mode, step, tri_v, modv, base, tgt;
        for (int c = 0; c < c_num_ch; c++) begin
            sel  = int'(s[4*c +: 2]);
            mode = int'(s[4*c+2 +: 2]);
            step = (mode == 2) ? 4 : ((mode == 0) ? 0 : 1);
            if (mode == 0) m_ph[c] = 0;
            else           m_ph[c] = (m_ph[c] + step) % 1024;
            tri_v = (m_ph[c] < 512) ? m_ph[c] : 1023 - m_ph[c];
            if (mode == 0)      modv = 0;
            else if (mode == 3) modv = m_ph[c] / (1 << (c_mod_shift + 1));
            else                modv = tri_v / (1 << c_mod_shift);
            base = (sel == 0) ? 500 : (sel == 1) ? 1000 : (sel == 2) ? 1500 : 0;
            tgt  = base + modv;
            if (tgt > c_max_del) tgt = c_max_del;
`ifdef DELAY_SLEW_EN
            if (tgt > m_del[c] + c_slew)      m_del[c] = m_del[c] + c_slew;
            else if (tgt < m_del[c] - c_slew) m_del[c] = m_del[c] - c_slew;
            else                              m_del[c] = tgt;
`else
            m_del[c] = tgt;
`endif
        end
    endfunction

    function automatic logic [c_num_ch*c_dw-1:0] model_vec();
        logic [c_num_ch*c_dw-1:0] v;
        for (int c = 0; c < c_num_ch; c++) v[c_dw*c +: c_dw] = c_dw'(m_del[c]);
        return v;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (bus.del_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: del_valid=1 with no outstanding tick (expected 0)");
            end else begin
                check("scoreboard_del", 64'(bus.del), 64'(exp_q.pop_front()));
            end
        end
    end

    // Issue one tick at the current cycle t (called just after a posedge) and
    // check busy, del_valid and the per-channel update edge through t+6.
    task automatic check_tick(input logic [4*c_num_ch-1:0] s);
        int old_del [c_num_ch];
        old_del      = m_del;
        bus.settings = s;
        bus.tick     = 1'b1;
        model_tick(s);
        exp_q.push_back(model_vec());
        @(negedge clk);
        check("busy_before", 64'(bus.busy), 64'(0));
        @(posedge clk); #1;
        bus.tick = 1'b0;
        for (int k = 1; k <= c_num_ch + 1; k++) begin
            @(negedge clk);
            check("busy_during", 64'(bus.busy), 64'(1));
            check("del_valid_cycle", 64'(bus.del_valid), 64'(k == c_num_ch + 1));
            check("overrun_quiet", 64'(bus.overrun), 64'(0));
            for (int c = 0; c < c_num_ch; c++) begin
                check("del_update_edge", 64'(dut_del(c)),
                      64'((c < k - 1) ? m_del[c] : old_del[c]));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("busy_after", 64'(bus.busy), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4*c_num_ch-1:0] s;
        model_reset();

        // Reset with tick held high: nothing may start.
        rst          = 1'b1;
        bus.tick     = 1'b1;
        bus.settings = 16'($urandom);
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        bus.tick = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("reset_del", 64'(bus.del), 64'(0));
            check("reset_busy", 64'(bus.busy), 64'(0));
            check("reset_del_valid", 64'(bus.del_valid), 64'(0));
            check("reset_overrun", 64'(bus.overrun), 64'(0));
            @(posedge clk); #1;
        end

        // Fixed ch0..ch2 patterns with a randomised ch3.
        for (int n = 1; n <= 1100; n++) begin
            s = {4'($urandom), 4'b1110, 4'b0100, 4'b0001};
            check_tick(s);
`ifdef DELAY_SLEW_EN
            if (n == 1)   check("slew_ch0_t1",   64'(dut_del(0)), 64'(16));
            if (n == 62)  check("slew_ch0_t62",  64'(dut_del(0)), 64'(992));
            if (n == 63)  check("slew_ch0_t63",  64'(dut_del(0)), 64'(1000));
            if (n == 100) check("slew_ch0_t100", 64'(dut_del(0)), 64'(1000));
`else
            if (n == 1)    check("tri_ch1_t1",    64'(dut_del(1)), 64'(500));
            if (n == 8)    check("tri_ch1_t8",    64'(dut_del(1)), 64'(501));
            if (n == 511)  check("tri_ch1_t511",  64'(dut_del(1)), 64'(563));
            if (n == 512)  check("tri_ch1_t512",  64'(dut_del(1)), 64'(563));
            if (n == 1024) check("tri_ch1_t1024", 64'(dut_del(1)), 64'(500));
            if (n == 64)   check("saw_ch2_t64",   64'(dut_del(2)), 64'(1504));
            if (n == 1024) check("saw_ch2_t1024", 64'(dut_del(2)), 64'(1500));
            if (n == 1)    check("fixed_ch0_t1",  64'(dut_del(0)), 64'(1000));
`endif
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        // Second tick two cycles after the first is dropped.
        bus.tick = 1'b1;
        model_tick(bus.settings);
        exp_q.push_back(model_vec());
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            bus.tick = (k == 2);
            @(negedge clk);
            check("overrun_pulse", 64'(bus.overrun), 64'(k == 3));
            check("overrun_busy", 64'(bus.busy), 64'(k <= 5));
        end
        @(posedge clk); #1;
        check("overrun_del_held", 64'(bus.del), 64'(model_vec()));

        // Reset two cycles into an update wipes everything; no del_valid.
        bus.tick = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            bus.tick = 1'b0;
            rst      = (k == 2);
            @(negedge clk);
            if (k >= 3) begin
                check("midrst_del", 64'(bus.del), 64'(0));
                check("midrst_busy", 64'(bus.busy), 64'(0));
                check("midrst_del_valid", 64'(bus.del_valid), 64'(0));
                check("midrst_overrun", 64'(bus.overrun), 64'(0));
            end
        end
        model_reset();
        @(posedge clk); #1;

        // Fully random settings, changing every tick.
        for (int n = 0; n < 200; n++) begin
            check_tick(16'($urandom));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (10) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
